btn_debouncer: RTL and testbench

- Upstream input stage of the game top level.
- Takes raw asynchronous pushbuttons btnU/btnL/btnR, synchronises them and debounces them against the 1 ms tick.
- Converts each debounced press into a one-cycle key_code event for the game state machine.
- Queues presses that arrive together and emits them one per cycle, so a press is never lost.

---
 rtl/btn_debouncer.sv | 181 ++++++++++++++++++
 tb/tb_btn_debouncer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debouncer.sv
`timescale 1ns/1ps
// btn_debouncer: sync, debounce and queue U/L/R buttons as key_code events.
// Define BTN_AUTO_REPEAT_EN for hold-to-repeat every REPEAT_MS ticks.
module btn_debouncer #(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned REPEAT_MS   = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       one_ms_tick,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  output logic [1:0] key_code,
  output logic       busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } btn_state_e;

  localparam logic [8:0] DEB_LIM = 9'(DEBOUNCE_MS);

  // bit 2 = U, bit 1 = L, bit 0 = R
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;

  btn_state_e state_q [3];
  btn_state_e state_d [3];
  logic [7:0] cnt_q [3];
  logic [7:0] cnt_d [3];

  logic [2:0] press_d;
  logic [2:0] press_q;
  logic [2:0] rep_ev;
  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic [2:0] clr;
  logic [1:0] code_d;

  assign raw = {btnU, btnL, btnR};

  // two-flop synchroniser per button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // debounced state, counters and the registered press strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      press_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      press_q <= press_d | rep_ev;
    end
  end

  // per-tick debounce count and IDLE/PRESSED transitions
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      press_d[i] = 1'b0;
      if (one_ms_tick) begin
        if (sync2[i] == (state_q[i] == PRESSED)) begin
          cnt_d[i] = '0;
        end else if ({1'b0, cnt_q[i]} + 9'd1 >= DEB_LIM) begin
          cnt_d[i] = '0;
          unique case (state_q[i])
            IDLE: begin
              state_d[i] = PRESSED;
              press_d[i] = 1'b1;
            end
            PRESSED: begin
              state_d[i] = IDLE;
            end
          endcase
        end else if (cnt_q[i] != 8'hFF) begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [10:0] REP_LIM = 11'(REPEAT_MS);

  logic [9:0] rep_q [3];
  logic [9:0] rep_d [3];

  // repeat timers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        rep_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        rep_q[i] <= rep_d[i];
      end
    end
  end

  // timer runs only while a button stays PRESSED
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rep_d[i]  = rep_q[i];
      rep_ev[i] = 1'b0;
      if (state_q[i] != PRESSED ||
          state_d[i] != PRESSED) begin
        rep_d[i] = '0;
      end else if (one_ms_tick) begin
        if ({1'b0, rep_q[i]} + 11'd1 >= REP_LIM) begin
          rep_d[i]  = '0;
          rep_ev[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + 10'd1;
        end
      end
    end
  end
`else
  assign rep_ev = '0;
`endif

  // highest pending flag wins: U, then L, then R
  always_comb begin
    clr    = '0;
    code_d = 2'd0;
    priority case (1'b1)
      pend_q[2]: begin
        clr    = 3'b100;
        code_d = 2'd1;
      end
      pend_q[1]: begin
        clr    = 3'b010;
        code_d = 2'd2;
      end
      pend_q[0]: begin
        clr    = 3'b001;
        code_d = 2'd3;
      end
      default: begin
        clr    = '0;
        code_d = 2'd0;
      end
    endcase
  end

  // a new press on the emitted flag survives the clear
  assign pend_d = (pend_q & ~clr) | press_q;

  // pending flags and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= '0;
      key_code <= 2'd0;
      busy     <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      key_code <= code_d;
      busy     <= |pend_q;
    end
  end

endmodule

// File: tb/tb_btn_debouncer.sv
`timescale 1ns/1ps
// tb_btn_debouncer: directed stimulus, behavioural model and per-cycle compare.
// Expected repeat count follows BTN_AUTO_REPEAT_EN.
module tb_btn_debouncer;

  localparam int DEB = 20;
  localparam int REP = 250;
  localparam int TP  = 10;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int HOLD_EXP = 5;
`else
  localparam int HOLD_EXP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       one_ms_tick = 1'b0;
  logic       btnU = 1'b0;
  logic       btnL = 1'b0;
  logic       btnR = 1'b0;
  logic [1:0] key_code;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int seen [4];

  btn_debouncer #(
    .DEBOUNCE_MS(DEB),
    .REPEAT_MS  (REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .one_ms_tick(one_ms_tick),
    .btnU       (btnU),
    .btnL       (btnL),
    .btnR       (btnR),
    .key_code   (key_code),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // free-running 1 ms strobe, one clk wide every TP clk
  initial begin
    forever begin
      repeat (TP - 1) @(posedge clk);
      #2 one_ms_tick = 1'b1;
      @(posedge clk);
      #2 one_ms_tick = 1'b0;
    end
  end

  // model state, index 0=U 1=L 2=R, code = index+1
  bit         m_s1 [3];
  bit         m_s2 [3];
  bit         m_lvl [3];
  int         m_run [3];
  int         m_held [3];
  bit         m_pend [3];
  bit         m_ev [3];
  bit         m_nev [3];
  bit         m_raw [3];
  logic [1:0] m_key = 2'd0;
  logic       m_busy = 1'b0;
  int         pick;

  initial begin
    forever begin
      @(posedge clk);
      m_raw[0] = btnU;
      m_raw[1] = btnL;
      m_raw[2] = btnR;
      if (!rst) begin
        for (int i = 0; i < 3; i++) begin
          m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0;
          m_run[i] = 0; m_held[i] = 0;
          m_pend[i] = 0; m_ev[i] = 0;
        end
        m_key = 2'd0;
        m_busy = 1'b0;
      end else begin
        pick = -1;
        for (int i = 0; i < 3; i++)
          if (m_pend[i] && pick < 0) pick = i;
        m_busy = (pick >= 0);
        m_key = (pick >= 0) ? 2'(pick + 1) : 2'd0;
        if (pick >= 0) m_pend[pick] = 0;
        for (int i = 0; i < 3; i++)
          if (m_ev[i]) m_pend[i] = 1;
        for (int i = 0; i < 3; i++) begin
          m_nev[i] = 0;
          if (one_ms_tick) begin
            if (m_s2[i] != m_lvl[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == DEB) begin
              m_run[i] = 0;
              m_lvl[i] = !m_lvl[i];
              if (m_lvl[i]) begin
                m_nev[i] = 1;
                m_held[i] = 0;
              end
            end else if (m_lvl[i]) begin
`ifdef BTN_AUTO_REPEAT_EN
              m_held[i]++;
              if (m_held[i] % REP == 0) m_nev[i] = 1;
`endif
            end
          end
        end
        for (int i = 0; i < 3; i++) begin
          m_ev[i] = m_nev[i];
          m_s2[i] = m_s1[i];
          m_s1[i] = m_raw[i];
        end
      end
    end
  end

  // per-cycle compare against the model; outputs are 0 during reset
  initial begin
    for (int i = 0; i < 4; i++) seen[i] = 0;
    forever begin
      @(negedge clk);
      chk($sformatf("key@%0d", cyc), int'(key_code),
          rst ? int'(m_key) : 0);
      chk($sformatf("busy@%0d", cyc), int'(busy),
          rst ? int'(m_busy) : 0);
      if (key_code != 2'd0) seen[key_code]++;
    end
  end

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (one_ms_tick) k++;
    end
    #2;
  endtask

  task automatic wait_key(input logic [1:0] code, input int lim,
                          output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (key_code == code) begin
        at = cyc;
        break;
      end
    end
    chk($sformatf("timeout_key%0d", code), int'(at >= 0), 1);
  endtask

  int s1, s2, s3, c20, at;

  task automatic snap();
    s1 = seen[1]; s2 = seen[2]; s3 = seen[3];
  endtask

  task automatic chk_ev(input string nm, input int u, input int l,
                        input int r);
    chk({nm, "_u"}, seen[1] - s1, u);
    chk({nm, "_l"}, seen[2] - s2, l);
    chk({nm, "_r"}, seen[3] - s3, r);
  endtask

  initial begin
    // reset held with btnU high
    rst = 1'b0;
    btnU = 1'b1;
    snap();
    wait_ticks(30);
    chk("rst_key", int'(key_code), 0);
    chk("rst_busy", int'(busy), 0);
    chk_ev("in_rst", 0, 0, 0);
    rst = 1'b1;
    wait_ticks(DEB - 2);
    chk_ev("rst_early", 0, 0, 0);
    wait_ticks(25);
    chk_ev("rst_rel", 1, 0, 0);
    btnU = 1'b0;
    wait_ticks(25);
    chk_ev("rst_up", 1, 0, 0);

    // clean press on L, latency from sync edge
    snap();
    btnL = 1'b1;
    @(posedge clk);
    @(posedge clk);
    begin
      int k = 0;
      while (k < DEB) begin
        @(posedge clk);
        if (one_ms_tick) k++;
      end
    end
    #1 c20 = cyc;
    wait_key(2'd2, 10, at);
    chk("clean_lat", at - c20, 2);
    wait_ticks(30);
    btnL = 1'b0;
    wait_ticks(30);
    chk_ev("clean", 0, 1, 0);

    // bouncing R
    snap();
    for (int j = 0; j < 5; j++) begin
      btnR = (j % 2 == 0);
      wait_ticks(3);
    end
    chk_ev("bounce_mid", 0, 0, 0);
    wait_ticks(30);
    chk_ev("bounce_end", 0, 0, 1);
    btnR = 1'b0;
    wait_ticks(30);
    chk_ev("bounce_rel", 0, 0, 1);

    // 19-tick glitch, then an exact 20-tick press
    snap();
    btnU = 1'b1;
    wait_ticks(DEB - 1);
    btnU = 1'b0;
    wait_ticks(25);
    chk_ev("glitch", 0, 0, 0);
    btnU = 1'b1;
    wait_ticks(DEB);
    btnU = 1'b0;
    wait_ticks(25);
    chk_ev("full20", 1, 0, 0);

    // simultaneous press
    snap();
    btnU = 1'b1;
    btnL = 1'b1;
    btnR = 1'b1;
    wait_key(2'd1, (DEB + 3) * TP, at);
    chk("sim0_key", int'(key_code), 1);
    chk("sim0_busy", int'(busy), 1);
    @(negedge clk);
    chk("sim1_key", int'(key_code), 2);
    chk("sim1_busy", int'(busy), 1);
    @(negedge clk);
    chk("sim2_key", int'(key_code), 3);
    chk("sim2_busy", int'(busy), 1);
    @(negedge clk);
    chk("sim3_key", int'(key_code), 0);
    chk("sim3_busy", int'(busy), 0);
    @(posedge clk);
    #2;
    btnU = 1'b0;
    btnL = 1'b0;
    btnR = 1'b0;
    wait_ticks(30);
    chk_ev("sim", 1, 1, 1);

    // long hold on L
    snap();
    btnL = 1'b1;
    wait_key(2'd2, (DEB + 3) * TP, at);
    wait_ticks(1000);
    btnL = 1'b0;
    wait_ticks(30);
    chk_ev("hold", 0, HOLD_EXP, 0);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
